// File: rtl/gfsk_pulse_shaper.sv
// GFSK bit-to-frequency shaper. Bits become +/-1 impulses, are zero-stuffed to
// SAMPLE_PER_SYMBOL samples, and pass through a multiplier-free Gaussian FIR.
module gfsk_pulse_shaper #(
   parameter int unsigned SAMPLE_PER_SYMBOL      = 8,
   parameter int unsigned NUM_TAP                = 17,
   parameter int unsigned TAP_ADDR_BIT_WIDTH     = 5,
   parameter int unsigned GAUSS_FILTER_BIT_WIDTH = 16,
   parameter int unsigned VCO_BIT_WIDTH          = 16
) (
   input  logic                                     clk,
   input  logic                                     rst_n,
   input  logic        [TAP_ADDR_BIT_WIDTH-1:0]     gauss_filter_tap_index,
   input  logic signed [GAUSS_FILTER_BIT_WIDTH-1:0] gauss_filter_tap_value,
   input  logic                                     gauss_filter_tap_write,
   input  logic                                     bit_in,
   input  logic                                     bit_in_valid,
   input  logic                                     bit_in_valid_last,
   output logic                                     bit_in_ready,
   output logic signed [VCO_BIT_WIDTH-1:0]          voltage_signal,
   output logic                                     voltage_signal_valid,
   output logic                                     voltage_signal_valid_last
);

   localparam int unsigned ACC_W  = GAUSS_FILTER_BIT_WIDTH + 5;
   localparam int unsigned CNT_W  = $clog2(SAMPLE_PER_SYMBOL);
   localparam int unsigned FCNT_W = $clog2(NUM_TAP);

   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SAMPLE_PER_SYMBOL - 1);
   localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(NUM_TAP - 2);

   localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2 ** (VCO_BIT_WIDTH - 1)) - 1);
   localparam logic signed [ACC_W-1:0] SAT_LO = -SAT_HI - ACC_W'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   state_t                                   state;
   logic        [CNT_W-1:0]                  cnt;
   logic        [FCNT_W-1:0]                 fcnt;
   logic                                     last_seen;
   logic        [NUM_TAP-1:0]                line_nz;
   logic        [NUM_TAP-1:0]                line_neg;
   logic signed [GAUSS_FILTER_BIT_WIDTH-1:0] coef [NUM_TAP];
   logic                                     push_q;
   logic                                     push_last_q;
   logic                                     accept;
   logic signed [ACC_W-1:0]                  acc;
   logic signed [VCO_BIT_WIDTH-1:0]          sat;

   // Coefficient bank; out-of-range addresses match no entry and are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_TAP; k++) begin
            coef[k] <= '0;
         end
      end else if (gauss_filter_tap_write) begin
         for (int k = 0; k < NUM_TAP; k++) begin
            if (gauss_filter_tap_index == TAP_ADDR_BIT_WIDTH'(k)) begin
               coef[k] <= gauss_filter_tap_value;
            end
         end
      end
   end

   // Each line entry is 0 or +/-1, so the dot product is add/subtract/skip.
   always_comb begin
      acc = '0;
      for (int k = 0; k < NUM_TAP; k++) begin
         if (line_nz[k]) begin
            if (line_neg[k]) begin
               acc = acc - ACC_W'(coef[k]);
            end else begin
               acc = acc + ACC_W'(coef[k]);
            end
         end
      end
   end

   always_comb begin
      sat = VCO_BIT_WIDTH'(acc);
      if (acc > SAT_HI) begin
         sat = VCO_BIT_WIDTH'(SAT_HI);
      end else if (acc < SAT_LO) begin
         sat = VCO_BIT_WIDTH'(SAT_LO);
      end
   end

   always_comb begin
      bit_in_ready = 1'b0;
      case (state)
         S_IDLE:  bit_in_ready = 1'b1;
         S_RUN:   bit_in_ready = (cnt == '0) && !last_seen;
         default: bit_in_ready = 1'b0;
      endcase
   end

   assign accept = bit_in_valid && bit_in_ready;

   // Symbol sequencing. The last RUN push hands straight over to FLUSH so the
   // tail stays contiguous with the payload samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         cnt         <= '0;
         fcnt        <= '0;
         last_seen   <= 1'b0;
         line_nz     <= '0;
         line_neg    <= '0;
         push_q      <= 1'b0;
         push_last_q <= 1'b0;
      end else begin
         push_q      <= 1'b0;
         push_last_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  line_nz   <= {line_nz[NUM_TAP-2:0], 1'b1};
                  line_neg  <= {line_neg[NUM_TAP-2:0], ~bit_in};
                  cnt       <= CNT_W'(1);
                  last_seen <= bit_in_valid_last;
                  push_q    <= 1'b1;
                  state     <= S_RUN;
               end
            end
            S_RUN: begin
               if (cnt != '0) begin
                  line_nz  <= {line_nz[NUM_TAP-2:0], 1'b0};
                  line_neg <= {line_neg[NUM_TAP-2:0], 1'b0};
                  push_q   <= 1'b1;
                  if (cnt == CNT_LAST) begin
                     cnt <= '0;
                     if (last_seen) begin
                        fcnt  <= '0;
                        state <= S_FLUSH;
                     end
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end else if (accept) begin
                  line_nz   <= {line_nz[NUM_TAP-2:0], 1'b1};
                  line_neg  <= {line_neg[NUM_TAP-2:0], ~bit_in};
                  cnt       <= CNT_W'(1);
                  last_seen <= bit_in_valid_last;
                  push_q    <= 1'b1;
               end
            end
            S_FLUSH: begin
               push_q <= 1'b1;
               if (fcnt == FCNT_LAST) begin
                  // Last impulse is already past the final tap, so clearing
                  // equals shifting in one more zero.
                  line_nz     <= '0;
                  line_neg    <= '0;
                  push_last_q <= 1'b1;
                  last_seen   <= 1'b0;
                  fcnt        <= '0;
                  state       <= S_IDLE;
               end else begin
                  line_nz  <= {line_nz[NUM_TAP-2:0], 1'b0};
                  line_neg <= {line_neg[NUM_TAP-2:0], 1'b0};
                  fcnt     <= fcnt + FCNT_W'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Output stage: one cycle after each push, holding value when idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         voltage_signal            <= '0;
         voltage_signal_valid      <= 1'b0;
         voltage_signal_valid_last <= 1'b0;
      end else begin
         voltage_signal_valid      <= push_q;
         voltage_signal_valid_last <= push_last_q;
         if (push_q) begin
            voltage_signal <= sat;
         end
      end
   end

endmodule

// File: tb/tb_gfsk_pulse_shaper.sv
// Bench for gfsk_pulse_shaper: table rows, random packets against a
// convolution model, coefficient-write timing and mid-packet reset.
module tb_gfsk_pulse_shaper;
   localparam int SPS = 8;
   localparam int NT  = 17;
   localparam int AW  = 5;
   localparam int GW  = 16;
   localparam int VW  = 16;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic        [AW-1:0] tap_index = '0;
   logic signed [GW-1:0] tap_value = '0;
   logic                 tap_write = 1'b0;
   logic                 bit_in = 1'b0;
   logic                 bit_in_valid = 1'b0;
   logic                 bit_in_valid_last = 1'b0;
   logic                 bit_in_ready;
   logic signed [VW-1:0] voltage_signal;
   logic                 voltage_signal_valid;
   logic                 voltage_signal_valid_last;

   always #5 clk = ~clk;

   gfsk_pulse_shaper #(
      .SAMPLE_PER_SYMBOL(SPS), .NUM_TAP(NT), .TAP_ADDR_BIT_WIDTH(AW),
      .GAUSS_FILTER_BIT_WIDTH(GW), .VCO_BIT_WIDTH(VW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .gauss_filter_tap_index(tap_index), .gauss_filter_tap_value(tap_value),
      .gauss_filter_tap_write(tap_write),
      .bit_in(bit_in), .bit_in_valid(bit_in_valid), .bit_in_valid_last(bit_in_valid_last),
      .bit_in_ready(bit_in_ready),
      .voltage_signal(voltage_signal), .voltage_signal_valid(voltage_signal_valid),
      .voltage_signal_valid_last(voltage_signal_valid_last)
   );

   typedef struct {
      logic [63:0] bits;
      int          nb;
      int          mode;
      int          gap_idx;
      int          gap_len;
      int          count;
      longint      sum;
      int          mn;
      int          mx;
      int          gap;
   } vec_t;

   vec_t   tab [7];
   int     total = 0;
   int     bad = 0;
   int     cyc = 0;
   int     mcoef [NT];
   int     exp_q [$];
   int     acc_cyc [64];
   int     pkt_base;

   int     got_v [$];
   bit     got_l [$];
   int     got_c [$];
   int     last_cnt = 0;
   int     stray_last = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (voltage_signal_valid) begin
         got_v.push_back(int'(voltage_signal));
         got_l.push_back(voltage_signal_valid_last);
         got_c.push_back(cyc);
         if (voltage_signal_valid_last) last_cnt++;
      end else if (voltage_signal_valid_last) begin
         stray_last++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   // Reference: zero-stuffed +/-1 sequence convolved with the taps, then clamped.
   task automatic build_expected(input int nb, input logic [63:0] bits);
      longint s;
      int     m;
      exp_q.delete();
      for (int n = 0; n < nb * SPS + NT - 1; n++) begin
         s = 0;
         for (int k = 0; k < NT; k++) begin
            m = n - k;
            if (m >= 0 && (m % SPS) == 0 && (m / SPS) < nb)
               s += bits[m / SPS] ? longint'(mcoef[k]) : -longint'(mcoef[k]);
         end
         if (s > 32767) s = 32767;
         if (s < -32768) s = -32768;
         exp_q.push_back(int'(s));
      end
   endtask

   task automatic set_coefs(input int mode);
      int v;
      for (int k = 0; k < NT; k++) begin
         case (mode)
            0:       v = k + 1;
            1:       v = 32767;
            2:       v = (k < 16) ? 4 : 0;
            default: v = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 8000)) - 4000
                                                     : int'($urandom_range(0, 65535)) - 32768;
         endcase
         mcoef[k]  = v;
         tap_index = AW'(k);
         tap_value = GW'(v);
         tap_write = 1'b1;
         @(negedge clk);
      end
      tap_write = 1'b0;
   endtask

   task automatic send_packet(input int nb, input logic [63:0] bits, input int gi, input int gl);
      int w;
      for (int i = 0; i < nb; i++) begin
         w = 0;
         while (!bit_in_ready && w < 100) begin
            @(negedge clk);
            w++;
         end
         if (!bit_in_ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout bit=%0d waited=%0d", i, w);
         end
         if (i == gi) repeat (gl) @(negedge clk);
         bit_in            = bits[i];
         bit_in_valid      = 1'b1;
         bit_in_valid_last = (i == nb - 1);
         acc_cyc[i]        = cyc;
         @(negedge clk);
         bit_in_valid      = 1'b0;
         bit_in_valid_last = 1'b0;
         bit_in            = 1'b0;
      end
   endtask

   task automatic wait_done(input int lbase);
      int w;
      w = 0;
      while (last_cnt == lbase && w < 500) begin
         @(negedge clk);
         w++;
      end
      if (last_cnt == lbase) begin
         total++;
         bad++;
         $display("FAIL last_timeout waited=%0d", w);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic check_packet(input string nm, input int base, input int lbase, input int sbase,
                               input int nb, input int gi, input int gl);
      int n;
      int exp_gap;
      n = got_v.size() - base;
      exp_gap = (gi > 0 && gi < nb) ? gl : 0;
      check({nm, "_count"}, n, exp_q.size());
      for (int i = 0; i < n && i < exp_q.size(); i++) begin
         check({nm, "_smp"}, got_v[base + i], exp_q[i]);
         check({nm, "_lastflag"}, got_l[base + i], (i == exp_q.size() - 1));
      end
      if (n > 0) begin
         check({nm, "_gap"}, got_c[base + n - 1] - got_c[base] + 1 - n, exp_gap);
         // accept edge, then one more edge to the registered sample
         check({nm, "_latency"}, got_c[base] - acc_cyc[0], 2);
      end
      for (int i = 1; i < nb; i++)
         check({nm, "_ready_spacing"}, acc_cyc[i] - acc_cyc[0],
               SPS * i + ((gi > 0 && i >= gi) ? gl : 0));
      check({nm, "_last_pulses"}, last_cnt - lbase, 1);
      check({nm, "_stray_last"}, stray_last - sbase, 0);
   endtask

   task automatic run_packet(input string nm, input int nb, input logic [63:0] bits,
                             input int gi, input int gl);
      int base, lbase, sbase;
      build_expected(nb, bits);
      base  = got_v.size();
      lbase = last_cnt;
      sbase = stray_last;
      send_packet(nb, bits, gi, gl);
      wait_done(lbase);
      check_packet(nm, base, lbase, sbase, nb, gi, gl);
      pkt_base = base;
   endtask

   initial begin
      int     base, lbase, sbase, nb, gi, gl, n, mn, mx;
      longint s;
      logic [63:0] rb;

      tab[0] = '{bits: 64'h1,  nb: 1, mode: 0, gap_idx: -1, gap_len: 0, count: 24, sum: 153,      mn: 0,      mx: 17,    gap: 0};
      tab[1] = '{bits: 64'h0,  nb: 1, mode: 0, gap_idx: -1, gap_len: 0, count: 24, sum: -153,     mn: -17,    mx: 0,     gap: 0};
      tab[2] = '{bits: 64'hD,  nb: 4, mode: 0, gap_idx: -1, gap_len: 0, count: 48, sum: 306,      mn: -8,     mx: 26,    gap: 0};
      tab[3] = '{bits: 64'hD,  nb: 4, mode: 0, gap_idx: 2,  gap_len: 5, count: 48, sum: 306,      mn: -8,     mx: 26,    gap: 5};
      tab[4] = '{bits: 64'hFF, nb: 8, mode: 1, gap_idx: -1, gap_len: 0, count: 80, sum: 2391991,  mn: 0,      mx: 32767, gap: 0};
      tab[5] = '{bits: 64'h00, nb: 8, mode: 1, gap_idx: -1, gap_len: 0, count: 80, sum: -2392048, mn: -32768, mx: 0,     gap: 0};
      tab[6] = '{bits: 64'hFF, nb: 8, mode: 2, gap_idx: -1, gap_len: 0, count: 80, sum: 512,      mn: 0,      mx: 8,     gap: 0};

      repeat (3) @(negedge clk);
      check("rst_volt", voltage_signal, 0);
      check("rst_valid", voltage_signal_valid, 0);
      check("rst_last", voltage_signal_valid_last, 0);
      check("rst_ready", bit_in_ready, 1);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_valid", voltage_signal_valid, 0);
      check("idle_ready", bit_in_ready, 1);

      for (int r = 0; r < 7; r++) begin
         set_coefs(tab[r].mode);
         run_packet($sformatf("vec%0d", r), tab[r].nb, tab[r].bits, tab[r].gap_idx, tab[r].gap_len);
         n = got_v.size() - pkt_base;
         s = 0;
         mn = 2147483647;
         mx = -2147483647;
         for (int i = pkt_base; i < got_v.size(); i++) begin
            s += got_v[i];
            if (got_v[i] < mn) mn = got_v[i];
            if (got_v[i] > mx) mx = got_v[i];
         end
         check($sformatf("vec%0d_tab_count", r), n, tab[r].count);
         check($sformatf("vec%0d_tab_sum", r), s, tab[r].sum);
         check($sformatf("vec%0d_tab_min", r), mn, tab[r].mn);
         check($sformatf("vec%0d_tab_max", r), mx, tab[r].mx);
         if (n > 0)
            check($sformatf("vec%0d_tab_gap", r), got_c[got_v.size() - 1] - got_c[pkt_base] + 1 - n, tab[r].gap);
      end

      for (int r = 0; r < 8; r++) begin
         set_coefs(3);
         nb = int'($urandom_range(1, 10));
         rb = {$urandom(), $urandom()};
         gi = (nb > 1 && $urandom_range(0, 1) != 0) ? int'($urandom_range(1, nb - 1)) : -1;
         gl = int'($urandom_range(1, 6));
         run_packet($sformatf("rnd%0d", r), nb, rb, gi, gl);
      end

      // Out-of-range write is dropped; a write on the accept edge feeds the first sum.
      set_coefs(0);
      tap_index = AW'(20);
      tap_value = GW'(500);
      tap_write = 1'b1;
      @(negedge clk);
      tap_write = 1'b0;
      mcoef[0] = 100;
      build_expected(1, 64'h1);
      base  = got_v.size();
      lbase = last_cnt;
      sbase = stray_last;
      check("cowr_ready", bit_in_ready, 1);
      bit_in = 1'b1;
      bit_in_valid = 1'b1;
      bit_in_valid_last = 1'b1;
      tap_index = AW'(0);
      tap_value = GW'(100);
      tap_write = 1'b1;
      acc_cyc[0] = cyc;
      @(negedge clk);
      bit_in_valid = 1'b0;
      bit_in_valid_last = 1'b0;
      tap_write = 1'b0;
      wait_done(lbase);
      check_packet("cowr", base, lbase, sbase, 1, -1, 0);

      // Reset in the middle of a packet.
      set_coefs(0);
      bit_in = 1'b1;
      bit_in_valid = 1'b1;
      bit_in_valid_last = 1'b0;
      @(negedge clk);
      bit_in_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("mid_valid_before", voltage_signal_valid, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_volt", voltage_signal, 0);
      check("mid_rst_valid", voltage_signal_valid, 0);
      check("mid_rst_last", voltage_signal_valid_last, 0);
      check("mid_rst_ready", bit_in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      base  = got_v.size();
      lbase = last_cnt;
      sbase = stray_last;
      repeat (40) @(negedge clk);
      check("post_rst_samples", got_v.size() - base, 0);
      check("post_rst_last", last_cnt - lbase, 0);
      check("post_rst_stray", stray_last - sbase, 0);
      check("post_rst_ready", bit_in_ready, 1);
      for (int k = 0; k < NT; k++) mcoef[k] = 0;
      run_packet("post_rst_zero_coef", 1, 64'h1, -1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
